// File: rtl/midi_spi_tx.sv
// -----------------------------------------------------------------------------
// midi_spi_tx
// Serialises a 1..3 byte MIDI message onto a mode-0 SPI link (SCLK idles low,
// MOSI MSB first, receiver samples on the rising edge).
// The bytes are: status, then the 7-bit data1, then the 7-bit data2.
// Every byte is followed by GAP_CYCLES idle clocks. A request with a zero
// length or a status byte without bit 7 set is rejected with a one-cycle
// msg_error pulse.
//
// Parameters
//   CLK_DIV     clk cycles per SCLK half-period (1..255)
//   GAP_CYCLES  idle clk cycles after every byte (1..255)
// Ports
//   clk         system clock, rising edge
//   reset       synchronous, active-low reset
//   msg_valid   upstream request
//   msg_ready   high only in IDLE; handshake = msg_valid & msg_ready
//   msg_status  status byte (bit 7 must be set)
//   msg_data1   first data byte (bits 6:0 used)
//   msg_data2   second data byte (bits 6:0 used)
//   msg_len     number of bytes to send (1..3)
//   msg_error   one-cycle pulse after a rejected request
//   SPI_sclk    registered SPI clock
//   SPI_mosi    registered SPI data
//   busy        high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module midi_spi_tx #(
   parameter int CLK_DIV    = 8,
   parameter int GAP_CYCLES = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       msg_valid,
   output logic       msg_ready,
   input  logic [7:0] msg_status,
   input  logic [7:0] msg_data1,
   input  logic [7:0] msg_data2,
   input  logic [1:0] msg_len,
   output logic       msg_error,
   output logic       SPI_sclk,
   output logic       SPI_mosi,
   output logic       busy
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SHIFT_LO = 2'd1,
      SHIFT_HI = 2'd2,
      GAP      = 2'd3
   } state_t;

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
   localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

   state_t     state_q, state_d;
   logic [7:0] div_q, div_d;       // shared by the half-period and gap timers
   logic [2:0] bit_q, bit_d;
   logic [1:0] byte_q, byte_d;
   logic [1:0] len_q, len_d;
   logic [7:0] shreg_q, shreg_d;   // byte in flight, bit 7 is on MOSI
   logic [6:0] data1_q, data1_d;
   logic [6:0] data2_q, data2_d;
   logic       sclk_q, sclk_d;
   logic       mosi_q, mosi_d;
   logic       busy_q, busy_d;
   logic       ready_q, ready_d;
   logic       error_q, error_d;

   // Bit 7 of the data bytes is dropped on purpose; folded here so it is not flagged as unused.
   logic unused_s;
   assign unused_s = ^{msg_data1[7], msg_data2[7]};

   // Next-state logic: FSM transitions, counters and the registered SPI pins.
   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      bit_d   = bit_q;
      byte_d  = byte_q;
      len_d   = len_q;
      shreg_d = shreg_q;
      data1_d = data1_q;
      data2_d = data2_q;
      sclk_d  = sclk_q;
      mosi_d  = mosi_q;
      error_d = 1'b0;

      case (state_q)
         IDLE: begin
            sclk_d = 1'b0;
            mosi_d = 1'b0;
            if (msg_valid && ready_q) begin
               if ((msg_len == 2'd0) || !msg_status[7]) begin
                  error_d = 1'b1;
               end else begin
                  // Everything needed later is captured in the handshake cycle.
                  state_d = SHIFT_LO;
                  div_d   = 8'd0;
                  bit_d   = 3'd0;
                  byte_d  = 2'd0;
                  len_d   = msg_len;
                  shreg_d = msg_status;
                  data1_d = msg_data1[6:0];
                  data2_d = msg_data2[6:0];
                  mosi_d  = msg_status[7];
               end
            end else begin
               state_d = IDLE;
            end
         end

         SHIFT_LO: begin
            if (div_q == DIV_LAST) begin
               state_d = SHIFT_HI;
               div_d   = 8'd0;
               sclk_d  = 1'b1;
            end else begin
               div_d = div_q + 8'd1;
            end
         end

         SHIFT_HI: begin
            if (div_q == DIV_LAST) begin
               div_d  = 8'd0;
               sclk_d = 1'b0;
               if (bit_q == 3'd7) begin
                  state_d = GAP;
                  mosi_d  = 1'b0;
               end else begin
                  // MOSI only moves when a new low phase starts.
                  state_d = SHIFT_LO;
                  bit_d   = bit_q + 3'd1;
                  shreg_d = {shreg_q[6:0], 1'b0};
                  mosi_d  = shreg_q[6];
               end
            end else begin
               div_d = div_q + 8'd1;
            end
         end

         GAP: begin
            if (div_q == GAP_LAST) begin
               div_d = 8'd0;
               if (byte_q == (len_q - 2'd1)) begin
                  state_d = IDLE;
               end else begin
                  state_d = SHIFT_LO;
                  byte_d  = byte_q + 2'd1;
                  bit_d   = 3'd0;
                  if (byte_q == 2'd0) begin
                     shreg_d = {1'b0, data1_q};
                  end else begin
                     shreg_d = {1'b0, data2_q};
                  end
                  mosi_d = 1'b0;
               end
            end else begin
               div_d = div_q + 8'd1;
            end
         end

         default: begin
            state_d = IDLE;
            div_d   = 8'd0;
            sclk_d  = 1'b0;
            mosi_d  = 1'b0;
         end
      endcase

      busy_d  = (state_d != IDLE);
      ready_d = (state_d == IDLE);
   end

   // State register with synchronous active-low reset; reset aborts any transfer.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         div_q   <= 8'd0;
         bit_q   <= 3'd0;
         byte_q  <= 2'd0;
         len_q   <= 2'd0;
         shreg_q <= 8'd0;
         data1_q <= 7'd0;
         data2_q <= 7'd0;
         sclk_q  <= 1'b0;
         mosi_q  <= 1'b0;
         busy_q  <= 1'b0;
         ready_q <= 1'b0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
         byte_q  <= byte_d;
         len_q   <= len_d;
         shreg_q <= shreg_d;
         data1_q <= data1_d;
         data2_q <= data2_d;
         sclk_q  <= sclk_d;
         mosi_q  <= mosi_d;
         busy_q  <= busy_d;
         ready_q <= ready_d;
         error_q <= error_d;
      end
   end

   assign msg_ready = ready_q;
   assign msg_error = error_q;
   assign SPI_sclk  = sclk_q;
   assign SPI_mosi  = mosi_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_midi_spi_tx.sv
// -----------------------------------------------------------------------------
// tb_midi_spi_tx
// Scoreboard bench for midi_spi_tx with CLK_DIV=2, GAP_CYCLES=4. The expected
// bytes are queued at each handshake. A receiver model samples MOSI on every
// SCLK rising edge and compares each completed byte with the queue head.
// -----------------------------------------------------------------------------
module tb_midi_spi_tx;

   localparam int CLK_DIV    = 2;
   localparam int GAP_CYCLES = 4;
   localparam int BYTE_CYC   = 16 * CLK_DIV + GAP_CYCLES;  // 36

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       msg_valid = 1'b0;
   logic [7:0] msg_status = 8'd0;
   logic [7:0] msg_data1 = 8'd0;
   logic [7:0] msg_data2 = 8'd0;
   logic [1:0] msg_len = 2'd0;
   logic       msg_ready;
   logic       msg_error;
   logic       SPI_sclk;
   logic       SPI_mosi;
   logic       busy;

   int         n_tests = 0;
   int         n_fail = 0;
   int         cyc = 0;
   int         rise_cnt = 0;
   int         rx_bits = 0;
   int         last_edge = -1;
   logic [7:0] rx_byte = 8'd0;
   logic       sclk_prev = 1'b0;
   logic [7:0] exp_q[$];

   midi_spi_tx #(.CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP_CYCLES)) dut (
      .clk        (clk),
      .reset      (reset),
      .msg_valid  (msg_valid),
      .msg_ready  (msg_ready),
      .msg_status (msg_status),
      .msg_data1  (msg_data1),
      .msg_data2  (msg_data2),
      .msg_len    (msg_len),
      .msg_error  (msg_error),
      .SPI_sclk   (SPI_sclk),
      .SPI_mosi   (SPI_mosi),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Advance to the next falling edge and run the SPI receiver model.
   task automatic tick();
      @(negedge clk);
      cyc++;
      if (!reset) begin
         rx_bits   = 0;
         last_edge = -1;
      end else if (SPI_sclk && !sclk_prev) begin
         rise_cnt++;
         rx_byte = {rx_byte[6:0], SPI_mosi};
         rx_bits++;
         if (rx_bits == 1 && last_edge >= 0) begin
            check_value("byte_gap", 32'((cyc - last_edge) >= (2 * CLK_DIV + GAP_CYCLES)), 32'd1);
         end
         if (rx_bits == 8) begin
            if (exp_q.size() == 0) begin
               check_value("rx_extra_byte", 32'(exp_q.size()), 32'd1);
            end else begin
               check_value("rx_byte", {24'd0, rx_byte}, {24'd0, exp_q.pop_front()});
            end
            rx_bits   = 0;
            last_edge = cyc;
         end
      end
      sclk_prev = SPI_sclk;
   endtask

   task automatic push_expected(input logic [7:0] st, input logic [7:0] d1, input logic [7:0] d2,
                                input logic [1:0] ln);
      exp_q.push_back(st);
      if (ln >= 2'd2) exp_q.push_back({1'b0, d1[6:0]});
      if (ln == 2'd3) exp_q.push_back({1'b0, d2[6:0]});
   endtask

   task automatic wait_ready(input string tag);
      int w;
      w = 0;
      while (!msg_ready && w < 2000) begin
         tick();
         w++;
      end
      check_value({tag, "_ready"}, {31'd0, msg_ready}, 32'd1);
   endtask

   // Issue one request, scramble the inputs after the handshake, and check the full response.
   task automatic send(input string tag, input logic [7:0] st, input logic [7:0] d1,
                       input logic [7:0] d2, input logic [1:0] ln);
      int   k;
      int   bc;
      int   r0;
      logic legal;
      wait_ready(tag);
      legal      = (ln != 2'd0) && st[7];
      msg_status = st;
      msg_data1  = d1;
      msg_data2  = d2;
      msg_len    = ln;
      msg_valid  = 1'b1;
      if (legal) push_expected(st, d1, d2, ln);
      r0 = rise_cnt;
      tick();
      msg_valid  = 1'b0;
      msg_status = ~st;
      msg_data1  = ~d1;
      msg_data2  = ~d2;
      msg_len    = ln + 2'd1;
      if (!legal) begin
         check_value({tag, "_err_pulse"}, {31'd0, msg_error}, 32'd1);
         check_value({tag, "_err_ready"}, {31'd0, msg_ready}, 32'd1);
         check_value({tag, "_err_busy"}, {31'd0, busy}, 32'd0);
         tick();
         check_value({tag, "_err_clear"}, {31'd0, msg_error}, 32'd0);
         repeat (6) tick();
         check_value({tag, "_err_edges"}, 32'(rise_cnt - r0), 32'd0);
         check_value({tag, "_err_sclk"}, {31'd0, SPI_sclk}, 32'd0);
      end else begin
         check_value({tag, "_first_mosi"}, {31'd0, SPI_mosi}, {31'd0, st[7]});
         check_value({tag, "_first_sclk"}, {31'd0, SPI_sclk}, 32'd0);
         check_value({tag, "_first_ready"}, {31'd0, msg_ready}, 32'd0);
         k  = 1;
         bc = 0;
         while (!msg_ready && k < 2000) begin
            if (busy) bc++;
            tick();
            k++;
         end
         check_value({tag, "_busy_cycles"}, 32'(bc), 32'(ln * BYTE_CYC));
         check_value({tag, "_ready_at"}, 32'(k), 32'(ln * BYTE_CYC + 1));
         check_value({tag, "_edges"}, 32'(rise_cnt - r0), 32'(8 * ln));
      end
   endtask

   initial begin
      int k;
      int r0;

      // Reset state
      reset = 1'b0;
      tick();
      check_value("rst_sclk", {31'd0, SPI_sclk}, 32'd0);
      check_value("rst_mosi", {31'd0, SPI_mosi}, 32'd0);
      check_value("rst_busy", {31'd0, busy}, 32'd0);
      check_value("rst_ready", {31'd0, msg_ready}, 32'd0);
      check_value("rst_error", {31'd0, msg_error}, 32'd0);
      tick();
      reset = 1'b1;
      tick();
      check_value("rst_release_ready", {31'd0, msg_ready}, 32'd1);

      send("note_on", 8'h90, 8'h3C, 8'h7F, 2'd3);
      send("clock_len1", 8'hF8, 8'hAA, 8'h55, 2'd1);
      send("bad_status", 8'h45, 8'h12, 8'h34, 2'd2);
      send("bad_len", 8'h90, 8'h12, 8'h34, 2'd0);
      send("data_mask", 8'hB0, 8'hBC, 8'hFF, 2'd3);
      send("len2", 8'hE3, 8'h81, 8'h66, 2'd2);

      // Reset 20 cycles into a three-byte message
      wait_ready("abort");
      msg_status = 8'h90;
      msg_data1  = 8'h3C;
      msg_data2  = 8'h7F;
      msg_len    = 2'd3;
      msg_valid  = 1'b1;
      tick();
      msg_valid = 1'b0;
      repeat (19) tick();
      reset = 1'b0;
      tick();
      check_value("abort_sclk", {31'd0, SPI_sclk}, 32'd0);
      check_value("abort_busy", {31'd0, busy}, 32'd0);
      exp_q.delete();
      r0 = rise_cnt;
      repeat (2) tick();
      reset = 1'b1;
      repeat (40) tick();
      check_value("abort_no_edges", 32'(rise_cnt - r0), 32'd0);
      send("after_abort", 8'h80, 8'h40, 8'h00, 2'd3);

      // Back-to-back with msg_valid held high
      wait_ready("b2b");
      msg_status = 8'h90;
      msg_data1  = 8'h3C;
      msg_data2  = 8'h7F;
      msg_len    = 2'd3;
      msg_valid  = 1'b1;
      push_expected(8'h90, 8'h3C, 8'h7F, 2'd3);
      tick();
      msg_status = 8'hC5;
      msg_data1  = 8'h11;
      msg_data2  = 8'h22;
      msg_len    = 2'd2;
      push_expected(8'hC5, 8'h11, 8'h22, 2'd2);
      k = 1;
      while (!msg_ready && k < 2000) begin
         tick();
         k++;
      end
      check_value("b2b_first_idle", 32'(k), 32'(3 * BYTE_CYC + 1));
      tick();
      msg_valid = 1'b0;
      check_value("b2b_second_busy", {31'd0, busy}, 32'd1);
      check_value("b2b_second_ready", {31'd0, msg_ready}, 32'd0);
      check_value("b2b_second_mosi", {31'd0, SPI_mosi}, 32'd1);
      k = 1;
      while (!msg_ready && k < 2000) begin
         tick();
         k++;
      end
      check_value("b2b_second_done", 32'(k), 32'(2 * BYTE_CYC + 1));
      repeat (5) tick();

      check_value("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
